// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per cycle, LSB first.
// Produces a full 2*WIDTH-bit product for unsigned or two's-complement operands.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
// Optional early exit when the remaining multiplier is zero: SEQ_MULT_EARLY_EXIT_EN.
module seq_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     product_q, product_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [PW-1:0]     addend, acc_sum;
   logic              last_iter;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
   always_comb begin
      a_mag = (is_signed && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
      b_mag = (is_signed && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
   end

   // Partial-product accumulation and end-of-calculation detection.
   always_comb begin
      addend  = mplier_q[0] ? (PW'(mcand_q) << count_q) : '0;
      acc_sum = acc_q + addend;
`ifdef SEQ_MULT_EARLY_EXIT_EN
      last_iter = (count_q == CNT_W'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
      last_iter = (count_q == CNT_W'(WIDTH - 1));
`endif
   end

   // Next-state logic for the FSM and datapath registers.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      neg_d     = neg_q;
      product_d = product_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               // A zero operand forces a positive result so -0 never appears.
               neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (a != '0) && (b != '0);
               acc_d    = '0;
               count_d  = '0;
               state_d  = StCalc;
            end
         end
         StCalc: begin
            acc_d    = acc_sum;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
            if (last_iter) begin
               product_d = neg_q ? (~acc_sum) + PW'(1) : acc_sum;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      product   = product_q;
   end

endmodule
